// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg: shared constants, state encoding and divisor helpers for clk_gen.
//   MIN_DIV    - smallest divisor the generator accepts
//   CNT_W_DEF  - default width of the divisor and counter
//   state_t    - idle / running
//   clamp_div  - raises any divisor below MIN_DIV to MIN_DIV
//   high_len   - number of high cycles in a period of N, ceil(N/2)
package clk_gen_pkg;

    localparam int unsigned MIN_DIV   = 2;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [31:0] clamp_div(input logic [31:0] n);
        return (n < MIN_DIV) ? MIN_DIV : n;
    endfunction

    // (N >> 1) + N[0] avoids the carry out of N + 1.
    function automatic logic [31:0] high_len(input logic [31:0] n);
        return (n >> 1) + {31'd0, n[0]};
    endfunction

endpackage

// File: rtl/clk_gen.sv
// clk_gen: programmable integer clock divider and clock-enable generator.
// Produces a registered divided clock (high for ceil(N/2) of every N cycles)
// and a one-cycle tick on each of its rising edges. Divisor changes and
// start/stop only take effect at period boundaries.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   en       in   run request (level)
//   div      in   requested divisor N, CNT_W bits
//   div_load in   capture div into the pending divisor on this edge
//   clk_out  out  divided clock, registered
//   tick     out  one-cycle pulse with each rising edge of clk_out
//   active   out  high while periods are being produced
module clk_gen
    import clk_gen_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             active
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_n_cur;
    logic [CNT_W-1:0] r_n_pend;
    logic             r_clk_out;
    logic             r_tick;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_n_cur_nxt;
    logic [CNT_W-1:0] w_n_pend_nxt;
    logic [CNT_W-1:0] w_h_cur;
    logic             w_clk_nxt;
    logic             w_tick_nxt;
    logic             w_at_end;

    assign w_h_cur   = CNT_W'(high_len(32'(r_n_cur)));
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_at_end  = (r_cnt == r_n_cur - CNT_W'(1));

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_n_cur_nxt  = r_n_cur;
        w_clk_nxt    = 1'b0;
        w_tick_nxt   = 1'b0;
        // A load on a period-end edge lands in n_pend after n_cur has
        // already taken the old pending value, so it applies a period later.
        w_n_pend_nxt = div_load ? CNT_W'(clamp_div(32'(div))) : r_n_pend;

        unique case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                    w_n_cur_nxt = r_n_pend;
                    w_clk_nxt   = 1'b1;
                    w_tick_nxt  = 1'b1;
                end
            end
            ST_RUN: begin
                if (!w_at_end) begin
                    w_cnt_nxt = w_cnt_inc;
                    w_clk_nxt = (w_cnt_inc < w_h_cur);
                end else if (en) begin
                    w_cnt_nxt   = '0;
                    w_n_cur_nxt = r_n_pend;
                    w_clk_nxt   = 1'b1;
                    w_tick_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_n_cur   <= CNT_W'(DEFAULT_DIV);
            r_n_pend  <= CNT_W'(DEFAULT_DIV);
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_n_cur   <= w_n_cur_nxt;
            r_n_pend  <= w_n_pend_nxt;
            r_clk_out <= w_clk_nxt;
            r_tick    <= w_tick_nxt;
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;
    assign active  = (r_state == ST_RUN);

endmodule

// File: tb/tb_clk_gen.sv
// tb_clk_gen: self-checking bench for clk_gen. A waveform-level reference
// model queues the expected {active, tick, clk_out} samples of each period
// when that period starts; every clock edge pops one sample and compares.
module tb_clk_gen;

    localparam int unsigned CNT_W       = 16;
    localparam int unsigned DEFAULT_DIV = 2;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [CNT_W-1:0] div;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic             active;

    clk_gen #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div      (div),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .active   (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: queue of future samples, pending divisor.
    logic [2:0]  m_q[$];
    int unsigned m_pend;
    logic [2:0]  m_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend = DEFAULT_DIV;
    endtask

    // One clock edge of the model, using the inputs as sampled at that edge.
    task automatic model_edge();
        int unsigned n;
        if (m_q.size() > 0) begin
            m_exp = m_q.pop_front();
        end else if (en) begin
            n     = m_pend;
            m_exp = 3'b111;
            for (int unsigned i = 1; i < n; i++)
                m_q.push_back({1'b1, 1'b0, (i < (n + 1) / 2)});
        end else begin
            m_exp = 3'b000;
        end
        if (div_load) m_pend = (int'(div) < 2) ? 2 : int'(div);
    endtask

    task automatic step(input logic e, input logic ld, input logic [CNT_W-1:0] d);
        en       = e;
        div_load = ld;
        div      = d;
        @(posedge clk);
        model_edge();
        #1;
        check("out{act,tick,clk}", {29'd0, active, tick, clk_out}, {29'd0, m_exp});
    endtask

    // Run with en low until the model says the generator has stopped.
    task automatic drain();
        int unsigned k;
        k = m_q.size() + 2;
        for (int unsigned i = 0; i < k; i++) step(1'b0, 1'b0, '0);
        check("drained_active", {31'd0, active}, 32'd0);
    endtask

    initial begin
        int unsigned highs;
        int unsigned ticks;
        rst_n    = 1'b0;
        en       = 1'b0;
        div      = '0;
        div_load = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", {29'd0, active, tick, clk_out}, 32'd0);
        rst_n = 1'b1;

        // Idle with en low, then default divisor N=2.
        repeat (3) step(1'b0, 1'b0, '0);
        repeat (10) step(1'b1, 1'b0, '0);
        drain();

        // N=5 loaded while idle.
        step(1'b0, 1'b1, 16'd5);
        repeat (16) step(1'b1, 1'b0, '0);
        drain();

        // N=4 running, load 6 at cnt=1.
        step(1'b0, 1'b1, 16'd4);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 16'd6);
        repeat (14) step(1'b1, 1'b0, '0);
        drain();

        // Clamp of 0 and 1.
        step(1'b0, 1'b1, 16'd0);
        repeat (6) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 16'd1);
        repeat (8) step(1'b1, 1'b0, '0);
        drain();

        // N=8, en dropped at cnt=2, then reasserted.
        step(1'b0, 1'b1, 16'd8);
        repeat (3) step(1'b1, 1'b0, '0);
        repeat (7) step(1'b0, 1'b0, '0);
        check("stopped_clk_out", {31'd0, clk_out}, 32'd0);
        repeat (4) step(1'b1, 1'b0, '0);
        drain();

        // Randomized en / div_load / div.
        for (int i = 0; i < 800; i++) begin
            logic e, ld;
            logic [CNT_W-1:0] d;
            e  = ($urandom_range(0, 9) < 7);
            ld = ($urandom_range(0, 7) == 0);
            d  = CNT_W'($urandom_range(0, 12));
            step(e, ld, d);
        end
        drain();

        // Largest divisor: one full period of 65535 cycles.
        step(1'b0, 1'b1, 16'hFFFF);
        highs = 0;
        ticks = 0;
        step(1'b1, 1'b0, '0);
        highs += clk_out;
        ticks += tick;
        for (int unsigned i = 1; i < 65535; i++) begin
            step(1'b0, 1'b0, '0);
            highs += clk_out;
            ticks += tick;
        end
        check("max_high_cycles", highs, 32'd32768);
        check("max_tick_count", ticks, 32'd1);
        step(1'b0, 1'b0, '0);
        check("max_ends_idle", {31'd0, active}, 32'd0);

        // Asynchronous reset in the high phase of N=10.
        step(1'b0, 1'b1, 16'd10);
        repeat (3) step(1'b1, 1'b0, '0);
        check("pre_reset_high", {31'd0, clk_out}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", {29'd0, active, tick, clk_out}, 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        repeat (8) step(1'b1, 1'b0, '0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_gen.md
Name: clk_gen

Overview:
Programmable integer clock divider and clock-enable generator. Derives a registered divided clock `clk_out` (≈50 % duty) and a one-cycle `tick` strobe from the system clock `clk`. It sits at the top of test and datapath hierarchies, for example as a source for counters. Divisor changes and start/stop are glitch-free and take effect only at period boundaries.

Parameters:
- CNT_W, 16: width of the divisor and of the internal counter.
- DEFAULT_DIV, 2: divisor loaded at reset. Must satisfy 2 ≤ DEFAULT_DIV ≤ 2^CNT_W−1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run request; level-sensitive.
- div  in  CNT_W  requested divisor N.
- div_load  in  1  when high on an edge, captures `div` into the pending divisor.
- clk_out  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse coincident with each rising edge of `clk_out`.
- active  out  1  high while the generator is producing periods.

Behaviour:
- Reset (async assert, sync release): cnt=0, clk_out=0, tick=0, active=0, n_pend=DEFAULT_DIV, n_cur=DEFAULT_DIV.
- Divisor clamp: a loaded `div` < 2 is stored as 2. No other clamping.
- div_load: n_pend <= clamp(div) on that edge. A later load overwrites an earlier unapplied one. Loads never alter n_cur mid-period.
- H = ceil(n_cur/2) = number of high cycles; low cycles = n_cur − H. For N=5: 3 high, 2 low.
- Idle (active=0), on each edge:
  - if en=1: active<=1, cnt<=0, n_cur<=n_pend, clk_out<=1, tick<=1.
  - if en=0: hold, with clk_out=0 and tick=0.
- Running (active=1), on each edge:
  - Not at end (cnt ≠ n_cur−1): cnt<=cnt+1, clk_out<=(cnt+1 < H_cur), tick<=0.
  - At end (cnt = n_cur−1) with en=1: cnt<=0, n_cur<=n_pend, clk_out<=1, tick<=1.
  - At end with en=0: active<=0, cnt<=0, clk_out<=0, tick<=0.
- Latency:
  - First rising edge of `clk_out` and first `tick` appear on the first `clk` edge where en=1 is sampled while idle.
  - A new divisor applies from the first period beginning after the load edge.
  - If div_load and the period end occur on the same edge, the old n_pend is used. The new value applies one period later.
- en deasserted mid-period: the current period always completes, so no runt pulses. en reasserted before the end: running continues seamlessly.
- Period of `clk_out` is exactly n_cur clk cycles, and `tick` has the same period.
- Reset mid-operation: outputs go to their reset values immediately (asynchronous), and the pending divisor reverts to DEFAULT_DIV.
- cnt width is CNT_W. No overflow is possible because cnt < n_cur ≤ 2^CNT_W−1.
- No combinational path from any input to any output.

Decomposition:
- Package `clk_gen_pkg`: constant MIN_DIV=2, default CNT_W, and a function `clamp_div` plus a function `high_len` (returns ceil(N/2)).
- Single module. No sub-module is needed; counter, divisor registers and output logic share one always block for sequential state plus combinational next-state.

Test Plan:
- Reset then en=1, DEFAULT_DIV=2 → clk_out toggles every clk cycle (1,0,1,0…), tick=1 on every second edge, active=1 from the first edge.
- div=5 loaded while idle, en=1 → clk_out pattern 1,1,1,0,0 repeating with period 5, tick at cnt=0 only.
- Running at N=4, div_load with div=6 at cnt=1 → current period finishes as 4 cycles (1,1,0,0), next period is 6 cycles (1,1,1,0,0,0).
- div=0 and div=1 loaded → behaves as N=2. div=65535 (CNT_W=16) → period 65535, 32768 cycles high.
- Running at N=8, en dropped at cnt=2 → period completes (high through cnt=3, low to cnt=7), then active=0 and clk_out=0. en reasserted → restart with a tick on the next edge.
- rst_n pulsed low mid-high-phase at N=10 → clk_out=0, tick=0, active=0 immediately without waiting for clk. After release with en=1, runs at DEFAULT_DIV.
